// File: rtl/axis_loopback_buf.sv
// axis_loopback_buf: MM2S-to-S2MM loopback with per-packet data transform,
// packet drop, synchronous FIFO and free-running statistics counters.
`default_nettype none

module axis_loopback_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]       s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic [USER_WIDTH-1:0]       s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,

  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,

  input  logic                        cnt_clr,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic [CNT_WIDTH-1:0]        pkt_count,
  output logic [CNT_WIDTH-1:0]        beat_count,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LVL_W   = ADDR_W + 1;
  localparam int LANES   = DATA_WIDTH / 32;
  localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_INC    = 2'd2;
  localparam logic [1:0] MODE_DROP   = 2'd3;

  typedef enum logic {
    ST_SOP = 1'b0,
    ST_MID = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       fill_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, beat_cnt_q, drop_cnt_q;
  logic [ENTRY_W-1:0]     mem_q [DEPTH];

  logic [1:0]             cur_mode;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  xform_data;
  logic [ENTRY_W-1:0]     head;

  // The first beat of a packet takes its mode straight from tuser.
  assign cur_mode      = (state_q == ST_SOP) ? s_axis_tuser[1:0] : mode_q;
  assign s_axis_tready = !rst && ((cur_mode == MODE_DROP) || (fill_q < FULL_LVL));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign push          = accept && (cur_mode != MODE_DROP);
  assign pop           = m_axis_tvalid && m_axis_tready;

  generate
    if (USER_WIDTH > 2) begin : g_tuser_unused
      logic unused_tuser;
      assign unused_tuser = ^s_axis_tuser[USER_WIDTH-1:2];
    end
  endgenerate

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [31:0] lane_in;
      assign lane_in = s_axis_tdata[32*g +: 32];
      assign xform_data[32*g +: 32] =
          (cur_mode == MODE_INVERT) ? ~lane_in :
          (cur_mode == MODE_INC)    ? lane_in + 32'd1 :
                                      lane_in;
    end
  endgenerate

  // Framer FSM: next state and mode latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (accept) begin
      if (state_q == ST_SOP) begin
        mode_d = s_axis_tuser[1:0];
      end
      state_d = s_axis_tlast ? ST_SOP : ST_MID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SOP;
      mode_q  <= MODE_PASS;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {xform_data, s_axis_tkeep, s_axis_tlast};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + LVL_W'(1);
        2'b01:   fill_q <= fill_q - LVL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Payload is masked while empty so the outputs read zero out of reset.
  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (fill_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[ENTRY_W-1 -: DATA_WIDTH] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[KEEP_WIDTH:1] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? head[0] : 1'b0;
  assign fill_level    = fill_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop) begin
        beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
      end
      if (pop && m_axis_tlast) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      end
      if (accept && (cur_mode == MODE_DROP) && s_axis_tlast) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign beat_count = beat_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_loopback_buf.sv
// tb_axis_loopback_buf: directed scenario tests for axis_loopback_buf.
`default_nettype none

module tb_axis_loopback_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_data;
  logic [15:0]  s_keep;
  logic         s_last;
  logic [7:0]   s_user;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic         cnt_clr;
  logic [4:0]   fill;
  logic [31:0]  pkt_cnt, beat_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_loopback_buf #(
    .DATA_WIDTH(128), .KEEP_WIDTH(16), .USER_WIDTH(8), .DEPTH(16), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .cnt_clr(cnt_clr), .fill_level(fill),
    .pkt_count(pkt_cnt), .beat_count(beat_cnt), .drop_count(drop_cnt)
  );

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b1; s_data = 128'hABCD; s_keep = '1; s_last = 1'b0;
    s_user = 8'h00; m_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_ready); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_valid); end
    checks++;
    if (m_data !== 128'd0 || m_keep !== 16'd0 || m_last !== 1'b0) begin
      errors++; $display("FAIL reset_payload: got %h/%h/%b expected 0/0/0", m_data, m_keep, m_last);
    end
    checks++;
    if (pkt_cnt !== 0 || beat_cnt !== 0 || drop_cnt !== 0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pkt_cnt, beat_cnt, drop_cnt);
    end
    s_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_pass;
    m_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk); #1;
      if (i > 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 128'(i) || m_last !== (i == 4)) begin
          errors++;
          $display("FAIL pass_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   i - 1, m_valid, m_data, m_last, 128'(i), (i == 4));
        end
      end
      if (i < 4) begin
        s_valid = 1'b1; s_data = 128'(i + 1); s_keep = '1; s_last = (i == 3); s_user = 8'h00;
      end else begin
        s_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pass_empty: got %b expected 0", m_valid); end
    checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL pass_pkt_count: got %0d expected 1", pkt_cnt); end
    checks++; if (beat_cnt !== 32'd4) begin errors++; $display("FAIL pass_beat_count: got %0d expected 4", beat_cnt); end
  endtask

  task automatic test_inc;
    m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = '1; s_user = 8'h02; s_last = 1'b0;
    @(negedge clk);
    s_data = {32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    s_user = 8'h01; s_last = 1'b1;
    @(negedge clk); #1;
    s_valid = 1'b0;
    checks++; if (fill !== 5'd2) begin errors++; $display("FAIL inc_fill: got %0d expected 2", fill); end
    checks++;
    if (m_data !== 128'd0 || m_last !== 1'b0) begin
      errors++; $display("FAIL inc_wrap: got %h l=%b expected 0 l=0", m_data, m_last);
    end
    m_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (m_data !== {32'h0000_0001, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF} || m_last !== 1'b1) begin
      errors++; $display("FAIL inc_latched: got %h l=%b expected 00000001000000028000_0000ffffffff l=1", m_data, m_last);
    end
    @(negedge clk); #1;
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL inc_empty: got %b expected 0", m_valid); end
    checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL inc_pkt_count: got %0d expected 2", pkt_cnt); end
    checks++; if (beat_cnt !== 32'd6) begin errors++; $display("FAIL inc_beat_count: got %0d expected 6", beat_cnt); end
  endtask

  task automatic test_invert_backpressure;
    int k;
    int out;
    logic do_pop;
    logic do_push;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 128'(i + 1); s_keep = '1; s_last = 1'b0;
      s_user = (i == 0) ? 8'h01 : 8'h00;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL inv_accept%0d: got tready=%b expected 1", i, s_ready); end
    end
    @(negedge clk);
    s_data = 128'd17; s_user = 8'h00;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL inv_full_tready: got %b expected 0", s_ready); end
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL inv_full_fill: got %0d expected 16", fill); end
    m_ready = 1'b1;
    k = 16;
    out = 0;
    for (int cyc = 0; cyc < 80 && out < 20; cyc++) begin
      if (k < 20) begin
        s_valid = 1'b1; s_data = 128'(k + 1); s_last = (k == 19);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      do_pop = m_valid;
      do_push = s_valid && s_ready;
      if (m_valid) begin
        checks++;
        if (m_data !== ~128'(out + 1) || m_last !== (out == 19)) begin
          errors++;
          $display("FAIL inv_out%0d: got %h l=%b expected %h l=%b", out, m_data, m_last, ~128'(out + 1), (out == 19));
        end
      end
      @(posedge clk);
      if (do_pop) out++;
      if (do_push) k++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++; if (out !== 20) begin errors++; $display("FAIL inv_timeout: got %0d beats expected 20", out); end
    #1;
    checks++; if (fill !== 5'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL inv_drained: got fill=%0d v=%b expected 0/0", fill, m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_drop_full;
    m_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 128'h5000 + 128'(j); s_user = 8'h00; s_last = (j == 15);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      s_data = 128'hDEAD + 128'(d); s_user = (d == 0) ? 8'h03 : 8'h00; s_last = (d == 2);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL drop_accept%0d: got tready=%b expected 1", d, s_ready); end
    end
    @(negedge clk); #1;
    s_valid = 1'b0;
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL drop_fill: got %0d expected 16", fill); end
    checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_cnt); end
    m_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 128'h5000 + 128'(j)) begin
        errors++; $display("FAIL drop_drain%0d: got v=%b d=%h expected v=1 d=%h", j, m_valid, m_data, 128'h5000 + 128'(j));
      end
      @(negedge clk); #1;
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drop_nothing_out: got %b expected 0", m_valid); end
    checks++; if (pkt_cnt !== 32'd4) begin errors++; $display("FAIL drop_pkt_count: got %0d expected 4", pkt_cnt); end
    checks++; if (beat_cnt !== 32'd42) begin errors++; $display("FAIL drop_beat_count: got %0d expected 42", beat_cnt); end
  endtask

  task automatic test_cnt_clr;
    m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = 128'h77; s_user = 8'h00; s_last = 1'b1;
    @(negedge clk); #1;
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_last !== 1'b1) begin errors++; $display("FAIL clr_head: got v=%b l=%b expected 1/1", m_valid, m_last); end
    m_ready = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); #1;
    m_ready = 1'b0; cnt_clr = 1'b0;
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL clr_pkt_count: got %0d expected 0", pkt_cnt); end
    checks++; if (beat_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL clr_others: got %0d/%0d expected 0/0", beat_cnt, drop_cnt); end
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 128'h900 + 128'(i); s_user = (i == 0) ? 8'h02 : 8'h00; s_last = 1'b0;
    end
    @(negedge clk); #1;
    s_valid = 1'b0;
    checks++; if (fill !== 5'd5) begin errors++; $display("FAIL rmid_fill: got %0d expected 5", fill); end
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rmid_tready: got %b expected 0", s_ready); end
    @(negedge clk); #1;
    rst = 1'b0;
    checks++;
    if (fill !== 5'd0 || m_valid !== 1'b0 || m_data !== 128'd0) begin
      errors++; $display("FAIL rmid_cleared: got fill=%0d v=%b d=%h expected 0/0/0", fill, m_valid, m_data);
    end
    s_valid = 1'b1; s_data = 128'h1234; s_user = 8'h01; s_last = 1'b1;
    @(negedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== ~128'h1234) begin
      errors++; $display("FAIL rmid_sop_invert: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, ~128'h1234);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_inc();
    test_invert_backpressure();
    test_drop_full();
    test_cnt_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
